// File: rtl/game_controller_pkg.sv
// Shared definitions for the stacking-game round sequencer: state encoding and widths.
package game_controller_pkg;

  localparam int STATE_W     = 3;
  localparam int SCORE_W_DEF = 7;
  localparam int CNT_W       = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } game_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level. The history flop resets to 1
// so a button held through reset produces no event.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic rise
);

  logic lvl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_q <= 1'b1;
    else      lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/game_controller.sv
// Round sequencer: IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> OVER, with registered enables.
// Optional session high score is built when GAME_CTRL_HIGH_SCORE_EN is defined.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int COUNTDOWN_SECS = 3,
  parameter int SCORE_W        = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_lvl,
  input  logic               pause_lvl,
  input  logic               sec_tick,
  input  logic               time_up,
  input  logic [SCORE_W-1:0] score,
  output logic               round_rst,
  output logic               stop,
  output logic               timer_run,
  output logic [CNT_W-1:0]   countdown,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] best_score
);

  logic              start_rise;
  logic              pause_rise;
  game_state_e       state_q;
  game_state_e       state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              round_rst_q;
  logic              stop_q;
  logic              timer_run_q;

  btn_edge u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  (start_lvl),
    .rise (start_rise)
  );

  btn_edge u_pause_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  (pause_lvl),
    .rise (pause_rise)
  );

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    if (start_rise) begin
      // A start edge restarts the round from any state, including an illegal one.
      if (COUNTDOWN_SECS == 0) begin
        state_nxt = ST_PLAY;
      end else begin
        state_nxt = ST_COUNTDOWN;
        cnt_nxt   = CNT_W'(COUNTDOWN_SECS);
      end
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_COUNTDOWN: begin
          cnt_nxt = cnt_q;
          if (sec_tick) begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_nxt   = '0;
              state_nxt = ST_PLAY;
            end else begin
              cnt_nxt = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_PLAY: begin
          if (time_up)         state_nxt = ST_OVER;
          else if (pause_rise) state_nxt = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (time_up)         state_nxt = ST_OVER;
          else if (pause_rise) state_nxt = ST_PLAY;
        end
        ST_OVER: state_nxt = ST_OVER;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      round_rst_q <= 1'b1;
      stop_q      <= 1'b1;
      timer_run_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      round_rst_q <= start_rise;
      stop_q      <= (state_nxt != ST_PLAY);
      timer_run_q <= (state_nxt == ST_PLAY);
    end
  end

`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [SCORE_W-1:0] best_q;

  // Only rst clears the high score; a new round keeps it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q <= '0;
    end else if ((state_nxt == ST_OVER) && (state_q != ST_OVER) && (score > best_q)) begin
      best_q <= score;
    end
  end

  assign best_score = best_q;
`else
  logic unused_score;
  assign unused_score = ^score;
  assign best_score   = '0;
`endif

  assign round_rst = round_rst_q;
  assign stop      = stop_q;
  assign timer_run = timer_run_q;
  assign countdown = cnt_q;
  assign state     = state_q;

endmodule
